// File: rtl/cw_ramp_bram_arbiter.sv
// Arbitrates one single-port CW ramp-profile BRAM between two round-robin readers and a loader.
// Define CW_RAMP_WRITE_VERIFY_EN to read back and compare every write before acknowledging it.
module cw_ramp_bram_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic              rd_req0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    output logic              rd_valid0,
    input  logic              rd_req1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid1,
    input  logic              busy0,
    input  logic              busy1,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    typedef enum logic [1:0] {StIdle, StWrite, StVerifyRd, StVerifyCmp} state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic                s1_vld_q, s1_vld_d, s1_tag_q, s1_tag_d;
    logic                s2_vld_q, s2_vld_d, s2_tag_q, s2_tag_d;
    logic                bram_en_q, bram_en_d, bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
    logic                rd_valid0_q, rd_valid0_d, rd_valid1_q, rd_valid1_d;
    logic [DATA_W-1:0]   rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
    logic                wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;

    logic inflight0, inflight1, elig0, elig1, rd_block, gnt0, gnt1, wr_gnt;

    // A reader stays ineligible until its tag has left the second pipeline stage.
    assign inflight0 = (s1_vld_q && !s1_tag_q) || (s2_vld_q && !s2_tag_q);
    assign inflight1 = (s1_vld_q && s1_tag_q) || (s2_vld_q && s2_tag_q);
    assign elig0     = rd_req0 && !inflight0;
    assign elig1     = rd_req1 && !inflight1;

`ifdef CW_RAMP_WRITE_VERIFY_EN
    assign rd_block = (state_q != StIdle);
`else
    assign rd_block = 1'b0;
`endif

    // prio_q names the reader that wins when both are eligible.
    assign gnt0   = !rd_block && elig0 && (!elig1 || !prio_q);
    assign gnt1   = !rd_block && elig1 && (!elig0 || prio_q);
    assign wr_gnt = wr_req && !busy0 && !busy1 && !elig0 && !elig1
                    && !s1_vld_q && !s2_vld_q && (state_q == StIdle);

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        s1_vld_d     = gnt0 || gnt1;
        s1_tag_d     = gnt1;
        s2_vld_d     = s1_vld_q;
        s2_tag_d     = s1_tag_q;
        rd_valid0_d  = s2_vld_q && !s2_tag_q;
        rd_valid1_d  = s2_vld_q && s2_tag_q;
        rd_data0_d   = rd_valid0_d ? bram_rdata : rd_data0_q;
        rd_data1_d   = rd_valid1_d ? bram_rdata : rd_data1_q;
        wr_ack_d     = 1'b0;
        wr_err_d     = 1'b0;

        if (gnt0 || gnt1) begin
            bram_en_d   = 1'b1;
            bram_addr_d = gnt1 ? rd_addr1 : rd_addr0;
            prio_d      = gnt0;
        end

        case (state_q)
            StIdle: begin
                if (wr_gnt) begin
                    bram_en_d    = 1'b1;
                    bram_we_d    = 1'b1;
                    bram_addr_d  = wr_addr;
                    bram_wdata_d = wr_data;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
`ifdef CW_RAMP_WRITE_VERIFY_EN
                // Read back the address just written; bram_addr_q still holds it.
                bram_en_d = 1'b1;
                state_d   = StVerifyRd;
`else
                wr_ack_d  = 1'b1;
                state_d   = StIdle;
`endif
            end
`ifdef CW_RAMP_WRITE_VERIFY_EN
            StVerifyRd: begin
                state_d = StVerifyCmp;
            end
            StVerifyCmp: begin
                wr_ack_d = 1'b1;
                wr_err_d = (bram_rdata != bram_wdata_q);
                state_d  = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            prio_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_tag_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_tag_q     <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            rd_valid0_q  <= 1'b0;
            rd_valid1_q  <= 1'b0;
            rd_data0_q   <= '0;
            rd_data1_q   <= '0;
            wr_ack_q     <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            s1_vld_q     <= s1_vld_d;
            s1_tag_q     <= s1_tag_d;
            s2_vld_q     <= s2_vld_d;
            s2_tag_q     <= s2_tag_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            rd_valid0_q  <= rd_valid0_d;
            rd_valid1_q  <= rd_valid1_d;
            rd_data0_q   <= rd_data0_d;
            rd_data1_q   <= rd_data1_d;
            wr_ack_q     <= wr_ack_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign rd_valid0  = rd_valid0_q;
    assign rd_valid1  = rd_valid1_q;
    assign rd_data0   = rd_data0_q;
    assign rd_data1   = rd_data1_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;

endmodule
